pc_predict_unit: RTL and testbench
==================================

Name: pc_predict_unit

Overview:
Parametrised fetch-stage program counter with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It replaces the plain PC + 4 / branch / jump / jr selector for the pipelined core. It produces the fetch address every cycle and predicts the next PC from the BTB. It accepts resolved-branch updates and full-address redirects from the execute stage.

Parameters:
XLEN, 32, address width in bits
BTB_DEPTH, 16, number of BTB entries; power of two, at least 2
RESET_PC, 0, fetch address loaded on reset; word aligned

Ports:
CLK  in  1  clock; all state updates on rising edge
Reset  in  1  reset; asynchronous, active-low
stall_i  in  1  hazard stall; hold fetch PC
redirect_i  in  1  EX-stage correction (mispredict, jump, jr)
redirect_pc_i  in  XLEN  corrected fetch address
upd_valid_i  in  1  resolved control-flow instruction this cycle
upd_is_branch_i  in  1  resolved instruction is a conditional branch
upd_pc_i  in  XLEN  address of the resolved instruction
upd_taken_i  in  1  actual direction
upd_target_i  in  XLEN  actual taken target
if_addr_o  out  XLEN  current fetch address (PC register)
if_pc4_o  out  XLEN  if_addr_o + 4, modulo 2^XLEN
pred_taken_o  out  1  BTB hit and counter >= 2 for if_addr_o
pred_target_o  out  XLEN  predicted next fetch address

Behaviour:
- Reset low (asynchronous): PC = RESET_PC; all entries valid = 0, tag = 0, target = 0, counter = 2'b01 (weakly not taken). Outputs follow: if_addr_o = RESET_PC, pred_taken_o = 0, pred_target_o = RESET_PC + 4. Reset asserted mid-operation discards any in-flight update that cycle.
- Indexing: idx = pc[IW+1:2], where IW = log2(BTB_DEPTH). tag = pc[XLEN-1:IW+2]. Bits [1:0] are ignored everywhere. redirect_pc_i[1:0] and upd_target_i[1:0] are forced to 0 when stored.
- Lookup is combinational on if_addr_o. hit = valid[idx] && tag match. pred_taken_o = hit && counter[1]. pred_target_o = the entry target when pred_taken_o, else if_pc4_o.
- Next-PC priority, at each rising edge:
  1. redirect_i: load redirect_pc_i. Redirect overrides stall_i.
  2. stall_i: hold.
  3. Otherwise: load pred_target_o.
- Fetch latency is zero: a new PC is visible on if_addr_o the cycle after the edge that loaded it.
- Update, on a rising edge when upd_valid_i && upd_is_branch_i. u_idx and u_tag are derived from upd_pc_i.
  - Hit, taken: counter saturating-increments (max 3); target = upd_target_i.
  - Hit, not taken: counter saturating-decrements (min 0); target unchanged.
  - Miss, taken: allocate (overwrite any entry). valid = 1, tag = u_tag, target = upd_target_i, counter = 2'b10.
  - Miss, not taken: no change.
- upd_valid_i with upd_is_branch_i = 0 (jump, jr) does not touch the BTB.
- Update is independent of stall_i and redirect_i.
- Same-cycle lookup and update to the same index: the lookup sees the old contents. The write is visible from the next cycle (no bypass).
- PC + 4 wraps from 2^XLEN - 4 to 0 with no flag.
- No X may propagate from uninitialised storage: every entry is reset.

Decomposition:
- Shared package pc_pkg:
  - counter encodings SNT = 2'b00, WNT = 2'b01, WT = 2'b10, ST = 2'b11
  - typedef for a BTB entry {valid, tag, target, ctr}
  - function sat_update(ctr, taken)
- One sub-module, btb_array. It holds the parametrised entry storage, the asynchronous read port (lookup), the synchronous write port (update) and the async reset clear.
- pc_predict_unit holds the PC register, the next-PC mux and the priority logic.

Test Plan:
1. Reset release with RESET_PC = 0, no stall -> if_addr_o = 0, 4, 8, 12 on successive cycles; pred_taken_o = 0 throughout.
2. stall_i high for 3 cycles at PC 0x10 -> if_addr_o holds 0x10. Then redirect_i = 1 with redirect_pc_i = 0x80 while still stalled -> next cycle if_addr_o = 0x80.
3. Update upd_pc_i = 0x20, taken, target 0x100 -> PC later reaches 0x20: pred_taken_o = 1, pred_target_o = 0x100, next if_addr_o = 0x100.
4. Same entry, two not-taken updates -> counter 10 -> 01 -> 00. At PC 0x20: pred_taken_o = 0, next PC = 0x24. Three taken updates saturate at 11; a fourth keeps it at 11.
5. Aliasing: with BTB_DEPTH = 16, 0x20 and 0x60 share index 8 -> 0x60 does not hit on 0x20's entry. A taken update at 0x60 evicts 0x20, which then misses.
6. Update and lookup to the same index in the same cycle -> prediction uses old data, new data on the next cycle. Reset pulsed mid-run -> PC = RESET_PC immediately, all entries invalid.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types for the fetch-stage PC predictor: direction counter encodings,
// the BTB entry layout and the saturating counter update.
package pc_pkg;

  localparam int unsigned XLEN_DEF      = 32;
  localparam int unsigned BTB_DEPTH_DEF = 16;
  localparam int unsigned IW_DEF        = $clog2(BTB_DEPTH_DEF);
  localparam int unsigned TAG_W_DEF     = XLEN_DEF - IW_DEF - 2;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;
  localparam ctr_t WNT = 2'b01;
  localparam ctr_t WT  = 2'b10;
  localparam ctr_t ST  = 2'b11;

  // Entry layout at the default geometry; btb_array rebuilds it from its own parameters.
  typedef struct packed {
    logic                    valid;
    logic [TAG_W_DEF-1:0]    tag;
    logic [XLEN_DEF-1:0]     target;
    ctr_t                    ctr;
  } btb_entry_t;

  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    ctr_t res;
    res = ctr;
    if (taken) begin
      if (ctr != ST) res = ctr + 2'd1;
    end else begin
      if (ctr != SNT) res = ctr - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch/execute-side bus of the PC predictor: stall, redirect, resolved-branch
// update in; fetch address and prediction out.
interface pc_predict_unit_if #(
  parameter int unsigned XLEN = 32
);

  logic            stall_i;
  logic            redirect_i;
  logic [XLEN-1:0] redirect_pc_i;
  logic            upd_valid_i;
  logic            upd_is_branch_i;
  logic [XLEN-1:0] upd_pc_i;
  logic            upd_taken_i;
  logic [XLEN-1:0] upd_target_i;
  logic [XLEN-1:0] if_addr_o;
  logic [XLEN-1:0] if_pc4_o;
  logic            pred_taken_o;
  logic [XLEN-1:0] pred_target_o;

  // Pipeline side: hazard unit / execute stage driving the predictor.
  modport master (
    output stall_i, redirect_i, redirect_pc_i,
    output upd_valid_i, upd_is_branch_i, upd_pc_i, upd_taken_i, upd_target_i,
    input  if_addr_o, if_pc4_o, pred_taken_o, pred_target_o
  );

  modport slave (
    input  stall_i, redirect_i, redirect_pc_i,
    input  upd_valid_i, upd_is_branch_i, upd_pc_i, upd_taken_i, upd_target_i,
    output if_addr_o, if_pc4_o, pred_taken_o, pred_target_o
  );

endinterface

// File: rtl/btb_array.sv
// Direct-mapped branch target buffer: async lookup port, sync update port
// with 2-bit saturating direction counters, every entry cleared on reset.
module btb_array
  import pc_pkg::*;
#(
  parameter int unsigned XLEN  = XLEN_DEF,
  parameter int unsigned DEPTH = BTB_DEPTH_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] rd_pc_i,
  output logic            rd_hit_c,
  output ctr_t            rd_ctr_c,
  output logic [XLEN-1:0] rd_target_c,
  input  logic            wr_en_i,
  input  logic [XLEN-1:0] wr_pc_i,
  input  logic            wr_taken_i,
  input  logic [XLEN-1:0] wr_target_i
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned TW = XLEN - IW - 2;

  typedef struct packed {
    logic            valid;
    logic [TW-1:0]   tag;
    logic [XLEN-1:0] target;
    ctr_t            ctr;
  } entry_t;

  localparam entry_t ENTRY_RST = '{valid: 1'b0, tag: '0, target: '0, ctr: WNT};

  entry_t          entry_q [DEPTH];
  entry_t          entry_d [DEPTH];

  logic [IW-1:0]   rd_idx;
  logic [TW-1:0]   rd_tag;
  entry_t          rd_entry;
  logic [IW-1:0]   wr_idx;
  logic [TW-1:0]   wr_tag;
  entry_t          wr_entry;
  logic            wr_hit;
  logic [XLEN-1:0] wr_target_al;
  logic            unused_lsbs;

  // Lookup sees only registered contents, so a same-cycle write is not bypassed.
  assign rd_idx      = rd_pc_i[IW+1:2];
  assign rd_tag      = rd_pc_i[XLEN-1:IW+2];
  assign rd_entry    = entry_q[rd_idx];
  assign rd_hit_c    = rd_entry.valid && (rd_entry.tag == rd_tag);
  assign rd_ctr_c    = rd_entry.ctr;
  assign rd_target_c = rd_entry.target;

  assign wr_idx       = wr_pc_i[IW+1:2];
  assign wr_tag       = wr_pc_i[XLEN-1:IW+2];
  assign wr_entry     = entry_q[wr_idx];
  assign wr_hit       = wr_entry.valid && (wr_entry.tag == wr_tag);
  assign wr_target_al = {wr_target_i[XLEN-1:2], 2'b00};

  assign unused_lsbs = ^{rd_pc_i[1:0], wr_pc_i[1:0], wr_target_i[1:0]};

  // Train on hit, allocate only on a taken miss; a not-taken miss leaves the table alone.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      entry_d[IW'(i)] = entry_q[IW'(i)];
    end
    if (wr_en_i) begin
      if (wr_hit) begin
        entry_d[wr_idx].ctr = sat_update(wr_entry.ctr, wr_taken_i);
        if (wr_taken_i) entry_d[wr_idx].target = wr_target_al;
      end else if (wr_taken_i) begin
        entry_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target_al, ctr: WT};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[IW'(i)] <= ENTRY_RST;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        entry_q[IW'(i)] <= entry_d[IW'(i)];
      end
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch-stage PC register with BTB-driven next-PC prediction; redirect beats
// stall beats predicted target.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN      = XLEN_DEF,
  parameter int unsigned     BTB_DEPTH = BTB_DEPTH_DEF,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input logic               CLK,
  input logic               Reset,
  pc_predict_unit_if.slave  bus
);

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] pc4_c;
  logic            btb_hit_c;
  ctr_t            btb_ctr_c;
  logic [XLEN-1:0] btb_target_c;
  logic            pred_taken_c;
  logic [XLEN-1:0] pred_target_c;
  logic            btb_wr_en_c;
  logic            unused_bits;

  assign btb_wr_en_c = bus.upd_valid_i && bus.upd_is_branch_i;

  btb_array #(
    .XLEN  (XLEN),
    .DEPTH (BTB_DEPTH)
  ) u_btb (
    .clk         (CLK),
    .rst_n       (Reset),
    .rd_pc_i     (pc_q),
    .rd_hit_c    (btb_hit_c),
    .rd_ctr_c    (btb_ctr_c),
    .rd_target_c (btb_target_c),
    .wr_en_i     (btb_wr_en_c),
    .wr_pc_i     (bus.upd_pc_i),
    .wr_taken_i  (bus.upd_taken_i),
    .wr_target_i (bus.upd_target_i)
  );

  assign pc4_c         = pc_q + XLEN'(4);
  assign pred_taken_c  = btb_hit_c && btb_ctr_c[1];
  assign pred_target_c = pred_taken_c ? btb_target_c : pc4_c;

  assign unused_bits = ^{bus.redirect_pc_i[1:0], btb_ctr_c[0]};

  // Next-PC select.
  always_comb begin
    pc_d = pc_q;
    if (bus.redirect_i) begin
      pc_d = {bus.redirect_pc_i[XLEN-1:2], 2'b00};
    end else if (!bus.stall_i) begin
      pc_d = pred_target_c;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  assign bus.if_addr_o     = pc_q;
  assign bus.if_pc4_o      = pc4_c;
  assign bus.pred_taken_o  = pred_taken_c;
  assign bus.pred_target_o = pred_target_c;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed bench for pc_predict_unit: sequencing, stall/redirect priority,
// BTB allocation, counter saturation, aliasing, no-bypass, wrap and mid-run reset.
module tb_pc_predict_unit;

  localparam int unsigned XLEN = 32;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  pc_predict_unit_if #(.XLEN(XLEN)) bus ();

  pc_predict_unit #(
    .XLEN      (XLEN),
    .BTB_DEPTH (16),
    .RESET_PC  (32'h0)
  ) dut (
    .CLK   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.stall_i         = 1'b0;
    bus.redirect_i      = 1'b0;
    bus.redirect_pc_i   = '0;
    bus.upd_valid_i     = 1'b0;
    bus.upd_is_branch_i = 1'b0;
    bus.upd_pc_i        = '0;
    bus.upd_taken_i     = 1'b0;
    bus.upd_target_i    = '0;
  endtask

  // Called at a negedge; moves PC to a and leaves it stalled there.
  task automatic goto_pc(input logic [31:0] a);
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = a;
    bus.stall_i       = 1'b1;
    @(negedge clk);
    bus.redirect_i    = 1'b0;
  endtask

  // Called at a negedge; presents one resolved update for one edge.
  task automatic upd(input logic [31:0] pc, input logic br, input logic tk, input logic [31:0] tgt);
    bus.upd_valid_i     = 1'b1;
    bus.upd_is_branch_i = br;
    bus.upd_pc_i        = pc;
    bus.upd_taken_i     = tk;
    bus.upd_target_i    = tgt;
    @(negedge clk);
    bus.upd_valid_i     = 1'b0;
    bus.upd_is_branch_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #3;
    n_cmp++; if (bus.if_addr_o !== 32'h0) begin n_err++; $display("FAIL reset_pc: got %h want %h", bus.if_addr_o, 32'h0); end
    n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL reset_taken: got %b want 0", bus.pred_taken_o); end
    n_cmp++; if (bus.pred_target_o !== 32'h4) begin n_err++; $display("FAIL reset_target: got %h want %h", bus.pred_target_o, 32'h4); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (bus.if_addr_o !== 32'(4*i)) begin n_err++; $display("FAIL seq_pc%0d: got %h want %h", i, bus.if_addr_o, 32'(4*i)); end
      n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL seq_taken%0d: got %b want 0", i, bus.pred_taken_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_stall_redirect();
    n_cmp++; if (bus.if_addr_o !== 32'h10) begin n_err++; $display("FAIL pre_stall_pc: got %h want %h", bus.if_addr_o, 32'h10); end
    bus.stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++; if (bus.if_addr_o !== 32'h10) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, bus.if_addr_o, 32'h10); end
    end
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h83;
    @(negedge clk);
    n_cmp++; if (bus.if_addr_o !== 32'h80) begin n_err++; $display("FAIL redirect_over_stall: got %h want %h", bus.if_addr_o, 32'h80); end
    bus.redirect_i = 1'b0;
    bus.stall_i    = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.if_addr_o !== 32'h84) begin n_err++; $display("FAIL resume_pc: got %h want %h", bus.if_addr_o, 32'h84); end
  endtask

  task automatic test_allocate();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h18;
    upd(32'h20, 1'b1, 1'b1, 32'h102);
    bus.redirect_i    = 1'b0;
    n_cmp++; if (bus.if_addr_o !== 32'h18) begin n_err++; $display("FAIL alloc_redir_pc: got %h want %h", bus.if_addr_o, 32'h18); end
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if (bus.if_addr_o !== 32'h20) begin n_err++; $display("FAIL alloc_reach_pc: got %h want %h", bus.if_addr_o, 32'h20); end
    n_cmp++; if (bus.pred_taken_o !== 1'b1) begin n_err++; $display("FAIL alloc_taken: got %b want 1", bus.pred_taken_o); end
    n_cmp++; if (bus.pred_target_o !== 32'h100) begin n_err++; $display("FAIL alloc_target: got %h want %h", bus.pred_target_o, 32'h100); end
    @(negedge clk);
    n_cmp++; if (bus.if_addr_o !== 32'h100) begin n_err++; $display("FAIL alloc_follow_pc: got %h want %h", bus.if_addr_o, 32'h100); end
  endtask

  task automatic test_counter();
    logic        tk    [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        exp_t [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [31:0] tgt;
    logic [31:0] last_tgt;
    goto_pc(32'h20);
    upd(32'h20, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL ctr_wnt: got %b want 0", bus.pred_taken_o); end
    upd(32'h20, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL ctr_snt: got %b want 0", bus.pred_taken_o); end
    n_cmp++; if (bus.pred_target_o !== 32'h24) begin n_err++; $display("FAIL ctr_snt_target: got %h want %h", bus.pred_target_o, 32'h24); end
    bus.stall_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.if_addr_o !== 32'h24) begin n_err++; $display("FAIL ctr_snt_next: got %h want %h", bus.if_addr_o, 32'h24); end
    goto_pc(32'h20);
    last_tgt = 32'h100;
    for (int i = 0; i < 6; i++) begin
      tgt = 32'h100 + 32'(16*i);
      upd(32'h20, 1'b1, tk[i], tgt);
      if (tk[i]) last_tgt = tgt;
      n_cmp++; if (bus.pred_taken_o !== exp_t[i]) begin n_err++; $display("FAIL ctr_step%0d: got %b want %b", i, bus.pred_taken_o, exp_t[i]); end
      if (exp_t[i]) begin
        n_cmp++; if (bus.pred_target_o !== last_tgt) begin n_err++; $display("FAIL ctr_tgt%0d: got %h want %h", i, bus.pred_target_o, last_tgt); end
      end
    end
  endtask

  task automatic test_alias();
    upd(32'h20, 1'b1, 1'b1, 32'h100);
    n_cmp++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h100) begin n_err++; $display("FAIL alias_own: got %b/%h want 1/%h", bus.pred_taken_o, bus.pred_target_o, 32'h100); end
    goto_pc(32'h60);
    n_cmp++; if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h64) begin n_err++; $display("FAIL alias_nohit: got %b/%h want 0/%h", bus.pred_taken_o, bus.pred_target_o, 32'h64); end
    upd(32'h60, 1'b1, 1'b0, 32'h999);
    goto_pc(32'h20);
    n_cmp++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h100) begin n_err++; $display("FAIL alias_nt_miss: got %b/%h want 1/%h", bus.pred_taken_o, bus.pred_target_o, 32'h100); end
    upd(32'h60, 1'b1, 1'b1, 32'h202);
    n_cmp++; if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h24) begin n_err++; $display("FAIL alias_evict: got %b/%h want 0/%h", bus.pred_taken_o, bus.pred_target_o, 32'h24); end
    goto_pc(32'h60);
    n_cmp++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h200) begin n_err++; $display("FAIL alias_new: got %b/%h want 1/%h", bus.pred_taken_o, bus.pred_target_o, 32'h200); end
    upd(32'h60, 1'b1, 1'b0, 32'h0);
    n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL alias_alloc_ctr: got %b want 0", bus.pred_taken_o); end
    upd(32'h40, 1'b0, 1'b1, 32'h300);
    goto_pc(32'h40);
    n_cmp++; if (bus.pred_taken_o !== 1'b0 || bus.pred_target_o !== 32'h44) begin n_err++; $display("FAIL jump_no_train: got %b/%h want 0/%h", bus.pred_taken_o, bus.pred_target_o, 32'h44); end
  endtask

  task automatic test_same_cycle();
    goto_pc(32'h30);
    bus.stall_i         = 1'b0;
    bus.upd_valid_i     = 1'b1;
    bus.upd_is_branch_i = 1'b1;
    bus.upd_pc_i        = 32'h30;
    bus.upd_taken_i     = 1'b1;
    bus.upd_target_i    = 32'h400;
    #1;
    n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL same_old_taken: got %b want 0", bus.pred_taken_o); end
    @(negedge clk);
    bus.upd_valid_i     = 1'b0;
    bus.upd_is_branch_i = 1'b0;
    n_cmp++; if (bus.if_addr_o !== 32'h34) begin n_err++; $display("FAIL same_old_next: got %h want %h", bus.if_addr_o, 32'h34); end
    goto_pc(32'h30);
    n_cmp++; if (bus.pred_taken_o !== 1'b1 || bus.pred_target_o !== 32'h400) begin n_err++; $display("FAIL same_new: got %b/%h want 1/%h", bus.pred_taken_o, bus.pred_target_o, 32'h400); end
  endtask

  task automatic test_wrap();
    goto_pc(32'hFFFF_FFFC);
    n_cmp++; if (bus.if_pc4_o !== 32'h0) begin n_err++; $display("FAIL wrap_pc4: got %h want %h", bus.if_pc4_o, 32'h0); end
    n_cmp++; if (bus.pred_target_o !== 32'h0) begin n_err++; $display("FAIL wrap_target: got %h want %h", bus.pred_target_o, 32'h0); end
    bus.stall_i = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.if_addr_o !== 32'h0) begin n_err++; $display("FAIL wrap_next: got %h want %h", bus.if_addr_o, 32'h0); end
  endtask

  task automatic test_mid_reset();
    goto_pc(32'h30);
    bus.stall_i         = 1'b0;
    bus.upd_valid_i     = 1'b1;
    bus.upd_is_branch_i = 1'b1;
    bus.upd_pc_i        = 32'h50;
    bus.upd_taken_i     = 1'b1;
    bus.upd_target_i    = 32'h500;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (bus.if_addr_o !== 32'h0) begin n_err++; $display("FAIL mid_reset_pc: got %h want %h", bus.if_addr_o, 32'h0); end
    n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_taken: got %b want 0", bus.pred_taken_o); end
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;
    goto_pc(32'h30);
    n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_clr30: got %b want 0", bus.pred_taken_o); end
    goto_pc(32'h50);
    n_cmp++; if (bus.pred_taken_o !== 1'b0) begin n_err++; $display("FAIL mid_reset_drop50: got %b want 0", bus.pred_taken_o); end
    goto_pc(32'h60);
    n_cmp++; if (bus.pred_taken_o !== 1'b0 || bus.if_addr_o !== 32'h60) begin n_err++; $display("FAIL mid_reset_clr60: got %b/%h want 0/%h", bus.pred_taken_o, bus.if_addr_o, 32'h60); end
  endtask

  initial begin
    test_reset();
    test_stall_redirect();
    test_allocate();
    test_counter();
    test_alias();
    test_same_cycle();
    test_wrap();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
